proc_run_sequencer: RTL and testbench
=====================================

# proc_run_sequencer

Parametrised run controller that drives one processor core through a batch of programs without bench intervention. For each program slot it selects the program, waits a settle delay, pulses `start`, and ignores `halt` during a minimum-run window. It then waits for `halt` or a watchdog timeout and records cycle count and status per slot. It sits between bench or host control and the `TopLevel` core, replacing hand-timed start/halt sequencing in directed benches.

## Interface
- `NUM_PROGS`, 4: program slots per batch (≥1); `PW = $clog2(NUM_PROGS)`, min 1.
- `START_DELAY`, 10: cycles between slot selection and `start` (≥1); ROM load window.
- `START_WIDTH`, 1: cycles `start` is held high (≥1).
- `MIN_RUN`, 55: count value below which `halt` is ignored.
- `TIMEOUT`, 4096: count value at which a run is declared hung (> `MIN_RUN`).
- `CNT_W`, 16: cycle counter / result width.
- `CLK` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: begin batch; sampled only in IDLE.
- `abort` in 1: synchronous abandon of the batch.
- `halt` in 1: core halt flag.
- `start` out 1: core start strobe.
- `prog_sel` out PW: slot currently loaded/running.
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse at batch completion (not on abort).
- `rd_idx` in PW: result read index.
- `rd_cycles` out CNT_W: recorded count of slot `rd_idx` (combinational read).
- `rd_status` out 2: 00 not run, 01 halted, 10 timeout, 11 aborted.

## Operation
- States: IDLE, DELAY, START, RUN, RECORD, DONE.
- IDLE: `go`=1 → clear all result entries to {0, 00}, `prog_sel`←0, → DELAY.
- DELAY: `START_DELAY` cycles, then → START.
- START: `start`=1 for `START_WIDTH` cycles; counter ←0 on first START cycle, then +1 per cycle; → RUN.
- RUN: counter +1 per cycle, saturating at 2^CNT_W−1. `halt` sampled with counter ≥ `MIN_RUN` → capture counter, status 01, → RECORD. Counter == `TIMEOUT` with no qualifying halt → capture `TIMEOUT`, status 10, → RECORD. Halt takes priority when both occur in the same cycle.
- `halt` high in DELAY, in START, or with counter < `MIN_RUN`: ignored and not recorded.
- RECORD: write entry[`prog_sel`]. If `prog_sel` == NUM_PROGS−1 → DONE; else `prog_sel`+1 → DELAY.
- DONE: `done`=1 for one cycle, → IDLE.
- `abort`=1 in any non-IDLE state: write status 11 with current counter to the current slot (if not already written), → IDLE. No `done`. `start` drops immediately. Abort beats halt/timeout in the same cycle.
- `go` while busy: ignored.
- Reset (async, any state): state IDLE, `start`=0, `busy`=0, `done`=0, `prog_sel`=0, counter 0, all entries {0, 00}. A run interrupted by reset leaves no record.

## Timing
- `go` sampled at edge 0 → `busy`=1 and DELAY in cycles 1..START_DELAY; `start`=1 in cycles START_DELAY+1 .. START_DELAY+START_WIDTH.
- Counter value in cycle n = n − (START_DELAY+1) for the first slot.
- Halt sampled in cycle h → result = counter in cycle h; RECORD in cycle h+1; next DELAY from h+2.
- Last RECORD in cycle r → `done`=1 and `busy`=1 in r+1; `busy`=0 from r+2.
- `rd_*` reflect a written entry from the cycle after RECORD.

## Test plan
- Defaults, NUM_PROGS=2: `go` at cycle 0; halt high at cycle 80 → `start` high only in cycle 11, slot 0 = {69, 01}; slot 1 runs and halts 60 cycles after its start → {60, 01}, `done` pulses once, `busy` drops next cycle.
- Early halt: halt high at count 29 and released, then high at count 70 → count-29 halt ignored, record {70, 01}.
- Hung core, TIMEOUT=200: halt never asserts → slot {200, 10}, sequencer advances to the next slot.
- Abort at count 40 in slot 1 → slot 0 keeps its result, slot 1 = {40, 11}, `start`=0, `busy` falls, no `done`.
- `rst_n` low mid-RUN of slot 0 → all outputs at reset values immediately (async), entries {0, 00}; a fresh `go` reruns from slot 0.
- `go` pulsed during RUN → no effect; simultaneous halt and timeout at count 200 → status 01.

Source files
------------

// File: rtl/proc_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : proc_run_sequencer
//  Purpose  : Batch run controller for one processor core. For each program
//             slot it selects the program, waits a settle delay, pulses start,
//             then waits for a qualified halt or a watchdog timeout and stores
//             the cycle count and completion status of that slot.
//  Revision : 1.0 - initial release
// ============================================================================
module proc_run_sequencer #(
    parameter int unsigned NUM_PROGS   = 4,
    parameter int unsigned START_DELAY = 10,
    parameter int unsigned START_WIDTH = 1,
    parameter int unsigned MIN_RUN     = 55,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned PW         = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             go_i,
    input  logic             abort_i,
    input  logic             halt_i,
    output logic             start_o,
    output logic [PW-1:0]    prog_sel_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic [PW-1:0]    rd_idx_i,
    output logic [CNT_W-1:0] rd_cycles_o,
    output logic [1:0]       rd_status_o
);

    // Timer covers both the settle delay and the start pulse width.
    localparam int unsigned TMAX  = (START_DELAY > START_WIDTH) ? START_DELAY : START_WIDTH;
    localparam int unsigned TW    = $clog2(TMAX + 1);
    localparam int unsigned NSLOT = 2 ** PW;

    localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [TW-1:0]    DLY_LAST  = TW'(START_DELAY - 1);
    localparam logic [TW-1:0]    STW_LAST  = TW'(START_WIDTH - 1);
    localparam logic [PW-1:0]    SEL_LAST  = PW'(NUM_PROGS - 1);

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    tmr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    sel_q;
    logic             start_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cap_cnt_q;
    logic [1:0]       cap_st_q;
    logic [CNT_W-1:0] cycles_q [NSLOT];
    logic [1:0]       status_q [NSLOT];

    logic [CNT_W-1:0] cnt_sat_d;
    logic             halt_ok;
    logic             timeout_hit;

    // Saturating increment and the two run-termination conditions.
    always_comb begin
        cnt_sat_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        halt_ok     = halt_i && (cnt_q >= MIN_RUN_C);
        timeout_hit = (cnt_q == TIMEOUT_C);
    end

    // Sequencer FSM with registered control outputs and the result table.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cap_cnt_q <= '0;
            cap_st_q  <= ST_NONE;
            for (int i = 0; i < NSLOT; i++) begin
                cycles_q[i] <= '0;
                status_q[i] <= ST_NONE;
            end
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                // A slot that already holds a result keeps it.
                if (status_q[sel_q] == ST_NONE) begin
                    cycles_q[sel_q] <= cnt_q;
                    status_q[sel_q] <= ST_ABORTED;
                end
                start_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (go_i) begin
                            for (int i = 0; i < NSLOT; i++) begin
                                cycles_q[i] <= '0;
                                status_q[i] <= ST_NONE;
                            end
                            sel_q   <= '0;
                            tmr_q   <= '0;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        if (tmr_q == DLY_LAST) begin
                            tmr_q   <= '0;
                            cnt_q   <= '0;
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                    S_START: begin
                        cnt_q <= cnt_sat_d;
                        if (tmr_q == STW_LAST) begin
                            start_q <= 1'b0;
                            state_q <= S_RUN;
                        end else begin
                            tmr_q <= tmr_q + TW'(1);
                        end
                    end
                    S_RUN: begin
                        // Halt wins over a coincident timeout.
                        if (halt_ok) begin
                            cap_cnt_q <= cnt_q;
                            cap_st_q  <= ST_HALTED;
                            state_q   <= S_RECORD;
                        end else if (timeout_hit) begin
                            cap_cnt_q <= TIMEOUT_C;
                            cap_st_q  <= ST_TIMEOUT;
                            state_q   <= S_RECORD;
                        end else begin
                            cnt_q <= cnt_sat_d;
                        end
                    end
                    S_RECORD: begin
                        cycles_q[sel_q] <= cap_cnt_q;
                        status_q[sel_q] <= cap_st_q;
                        if (sel_q == SEL_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            sel_q   <= sel_q + PW'(1);
                            tmr_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DELAY;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        start_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign prog_sel_o  = sel_q;
    assign rd_cycles_o = cycles_q[rd_idx_i];
    assign rd_status_o = status_q[rd_idx_i];

endmodule
`default_nettype wire

// File: tb/tb_proc_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_proc_run_sequencer
//  Purpose  : Directed table-driven bench for proc_run_sequencer with two
//             program slots and a short watchdog (TIMEOUT = 200).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_proc_run_sequencer;

    localparam int NUM_PROGS   = 2;
    localparam int START_DELAY = 10;
    localparam int START_WIDTH = 1;
    localparam int MIN_RUN     = 55;
    localparam int TIMEOUT     = 200;
    localparam int CNT_W       = 16;

    logic        clk;
    logic        rst_n;
    logic        go_i;
    logic        abort_i;
    logic        halt_i;
    logic        start_o;
    logic [0:0]  prog_sel_o;
    logic        busy_o;
    logic        done_o;
    logic [0:0]  rd_idx_i;
    logic [15:0] rd_cycles_o;
    logic [1:0]  rd_status_o;

    int n_vec = 0;
    int n_bad = 0;

    proc_run_sequencer #(
        .NUM_PROGS   (NUM_PROGS),
        .START_DELAY (START_DELAY),
        .START_WIDTH (START_WIDTH),
        .MIN_RUN     (MIN_RUN),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .go_i        (go_i),
        .abort_i     (abort_i),
        .halt_i      (halt_i),
        .start_o     (start_o),
        .prog_sel_o  (prog_sel_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_idx_i    (rd_idx_i),
        .rd_cycles_o (rd_cycles_o),
        .rd_status_o (rd_status_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One batch: halt/abort/go positions are counts relative to each slot's
    // start cycle (-1 = never); c*/st* are the hand-computed results.
    typedef struct packed {
        int h0a;    // early halt pulse in slot 0
        int h0;     // qualifying halt in slot 0
        int h1;     // halt in slot 1
        int c0;
        int st0;
        int c1;
        int st1;
        int noise;  // extra halt pulses in DELAY/START
        int gop;    // go pulse in slot 0 run
        int ab1;    // abort in slot 1
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_vec(input logic s, input logic b, input logic d, input logic p);
        return {28'b0, s, b, d, p};
    endfunction

    function automatic logic [31:0] rd_vec(input int c, input int s);
        logic [15:0] cc;
        logic [1:0]  ss;
        cc = c[15:0];
        ss = s[1:0];
        return {14'b0, cc, ss};
    endfunction

    task automatic run_batch(input int id, input vec_t v);
        int s0, s1, rec0, rec1, ab_cyc, last_busy, last_n;
        logic e_start, e_busy, e_done, e_sel;
        s0        = START_DELAY + 1;
        rec0      = s0 + v.c0 + 1;
        s1        = s0 + v.c0 + 2 + START_DELAY;
        rec1      = s1 + v.c1 + 1;
        ab_cyc    = (v.ab1 >= 0) ? s1 + v.ab1 : -1;
        last_busy = (v.ab1 >= 0) ? ab_cyc : rec1 + 1;
        last_n    = last_busy + 3;
        rd_idx_i  = 1'b0;
        @(posedge clk);
        #1;
        go_i = 1'b1;
        @(posedge clk);  // edge 0
        for (int n = 1; n <= last_n; n++) begin
            #1;
            e_start = (n == s0) || (n == s1);
            e_busy  = (n <= last_busy);
            e_done  = (v.ab1 < 0) && (n == rec1 + 1);
            e_sel   = (n > rec0);
            check($sformatf("v%0d ctrl cyc%0d", id, n),
                  ctrl_vec(start_o, busy_o, done_o, prog_sel_o[0]),
                  ctrl_vec(e_start, e_busy, e_done, e_sel));
            if (n == 1)
                check($sformatf("v%0d slot0 cleared", id), rd_vec(rd_cycles_o, rd_status_o), rd_vec(0, 0));
            if (n == rec0)
                check($sformatf("v%0d slot0 in RECORD", id), rd_vec(rd_cycles_o, rd_status_o), rd_vec(0, 0));
            if (n == rec0 + 1)
                check($sformatf("v%0d slot0 after RECORD", id), rd_vec(rd_cycles_o, rd_status_o), rd_vec(v.c0, v.st0));
            halt_i  = ((v.h0a >= 0) && (n == s0 + v.h0a)) ||
                      ((v.h0  >= 0) && (n == s0 + v.h0))  ||
                      ((v.h1  >= 0) && (n == s1 + v.h1))  ||
                      ((v.noise != 0) && ((n == 5) || (n == s0) || (n == s1 - 3)));
            go_i    = (v.gop >= 0) && (n == s0 + v.gop);
            abort_i = (v.ab1 >= 0) && (n == ab_cyc);
            @(posedge clk);
        end
        #1;
        halt_i  = 1'b0;
        go_i    = 1'b0;
        abort_i = 1'b0;
        rd_idx_i = 1'b0;
        #1;
        check($sformatf("v%0d final slot0", id), rd_vec(rd_cycles_o, rd_status_o), rd_vec(v.c0, v.st0));
        rd_idx_i = 1'b1;
        #1;
        check($sformatf("v%0d final slot1", id), rd_vec(rd_cycles_o, rd_status_o), rd_vec(v.c1, v.st1));
        rd_idx_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rerun;
        //          h0a  h0   h1   c0   st0 c1   st1 noise gop  ab1
        tbl[0] = '{ -1,  69,  60,  69,  1,  60,  1,  0,   -1,  -1 };  // baseline
        tbl[1] = '{ 29,  70,  60,  70,  1,  60,  1,  1,   -1,  -1 };  // early halt + noise
        tbl[2] = '{ -1,  -1, 100, 200,  2, 100,  1,  0,   -1,  -1 };  // hung slot 0
        tbl[3] = '{ -1, 200,  -1, 200,  1, 200,  2,  0,  100,  -1 };  // halt==timeout, go ignored
        tbl[4] = '{ 54,  55,  56,  55,  1,  56,  1,  0,   -1,  -1 };  // MIN_RUN boundary
        tbl[5] = '{ -1,  69,  -1,  69,  1,  40,  3,  0,   -1,  40 };  // abort in slot 1
        tbl[6] = '{ -1,  69, 120,  69,  1, 120,  3,  0,   -1, 120 };  // abort beats halt

        rst_n    = 1'b0;
        go_i     = 1'b0;
        abort_i  = 1'b0;
        halt_i   = 1'b0;
        rd_idx_i = 1'b0;
        #12;
        check("reset ctrl", ctrl_vec(start_o, busy_o, done_o, prog_sel_o[0]), ctrl_vec(0, 0, 0, 0));
        check("reset rd", rd_vec(rd_cycles_o, rd_status_o), rd_vec(0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_batch(i, tbl[i]);

        // Asynchronous reset in the middle of slot 0's run (count 29).
        @(posedge clk);
        #1;
        go_i = 1'b1;
        @(posedge clk);
        #1;
        go_i = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("pre-reset busy", ctrl_vec(start_o, busy_o, done_o, prog_sel_o[0]), ctrl_vec(0, 1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset ctrl", ctrl_vec(start_o, busy_o, done_o, prog_sel_o[0]), ctrl_vec(0, 0, 0, 0));
        check("async reset slot0", rd_vec(rd_cycles_o, rd_status_o), rd_vec(0, 0));
        rd_idx_i = 1'b1;
        #1;
        check("async reset slot1", rd_vec(rd_cycles_o, rd_status_o), rd_vec(0, 0));
        rd_idx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("held reset ctrl", ctrl_vec(start_o, busy_o, done_o, prog_sel_o[0]), ctrl_vec(0, 0, 0, 0));
        rst_n = 1'b1;

        // Fresh batch after reset starts again from slot 0.
        rerun = '{ -1, 60, 57, 60, 1, 57, 1, 0, -1, -1 };
        run_batch(7, rerun);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
